// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer_pkg
// Description : Shared constants for the shift sequencer: FSM state codes,
//               shift-register control codes and command direction codes.
// Revision    : 1.0  initial release
// ============================================================================
package shift_sequencer_pkg;

    // FSM state encodings
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_capt  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Shift register control, bit order {LSH, RSH}
    localparam logic [1:0] c_sh_hold = 2'b00;
    localparam logic [1:0] c_sh_rsh  = 2'b01;
    localparam logic [1:0] c_sh_lsh  = 2'b10;

    // Command direction codes
    localparam logic c_dir_left  = 1'b0;
    localparam logic c_dir_right = 1'b1;

endpackage : shift_sequencer_pkg
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle controller for an external WIDTH-bit shift
//               register. Accepts {operand, direction, amount} on a
//               valid/ready command port, loads the operand, issues one
//               single-bit shift per cycle, then presents result, carry-out
//               and zero flag on a valid/ready result port.
// Ports       : CLK, RESET (sync, active-low)
//               CMD_VALID/CMD_READY/CMD_DIR/CMD_AMT/CMD_DATA - command in
//               SR_DATA/SR_LOAD/SR_SHIFT/SR_Q                - shift register
//               RES_VALID/RES_READY/RES_DATA/RES_CARRY/RES_ZERO - result out
//               BUSY                                          - not idle
// Revision    : 1.0  initial release
// ============================================================================
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_DIR,
    input  logic [CNT_W-1:0] CMD_AMT,
    input  logic [WIDTH-1:0] CMD_DATA,
    output logic [WIDTH-1:0] SR_DATA,
    output logic             SR_LOAD,
    output logic [1:0]       SR_SHIFT,
    input  logic [WIDTH-1:0] SR_Q,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic             RES_CARRY,
    output logic             RES_ZERO,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] c_amt_max = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_amt_one = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_zero;
    logic             w_accept;
    logic [CNT_W-1:0] w_amt_sat;

    // Ready is gated by RESET so that no command can be taken on the very
    // edge that resets the block.
    assign CMD_READY = (r_state == c_st_idle) && RESET;
    assign w_accept  = CMD_VALID && CMD_READY;
    assign w_amt_sat = (CMD_AMT > c_amt_max) ? c_amt_max : CMD_AMT;

    assign RES_VALID = (r_state == c_st_done);
    assign RES_DATA  = r_res_data;
    assign RES_CARRY = r_carry;
    assign RES_ZERO  = r_res_zero;
    assign BUSY      = (r_state != c_st_idle);

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and shift register control
    always_comb begin
        w_state_nxt = r_state;
        SR_LOAD     = 1'b0;
        SR_SHIFT    = c_sh_hold;
        SR_DATA     = r_data;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                SR_LOAD     = 1'b1;
                w_state_nxt = (r_cnt == '0) ? c_st_capt : c_st_shift;
            end
            c_st_shift: begin
                SR_SHIFT = (r_dir == c_dir_right) ? c_sh_rsh : c_sh_lsh;
                // The shift issued in this cycle is the last one when the
                // counter still reads 1.
                if (r_cnt == c_amt_one) begin
                    w_state_nxt = c_st_capt;
                end
            end
            c_st_capt: begin
                w_state_nxt = c_st_done;
            end
            c_st_done: begin
                if (RES_READY) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Command latch, down-counter, carry and result registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_data     <= '0;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_res_data <= '0;
            r_res_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= CMD_DATA;
                r_dir   <= CMD_DIR;
                r_cnt   <= w_amt_sat;
                r_carry <= 1'b0;
            end
            if (r_state == c_st_shift) begin
                // SR_Q still holds the pre-shift value at this edge, so the
                // edge bit is exactly the one leaving the register.
                r_carry <= (r_dir == c_dir_right) ? SR_Q[0] : SR_Q[WIDTH-1];
                r_cnt   <= r_cnt - c_amt_one;
            end
            if (r_state == c_st_capt) begin
                r_res_data <= SR_Q;
                r_res_zero <= (SR_Q == '0);
            end
        end
    end

endmodule : shift_sequencer
`default_nettype wire
